// File: rtl/dma_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_cfg_pkg
// Description : Shared constants for the DMA register-programming sequencer:
//               DMA core register offsets, control-register bits, FSM state
//               encoding and the step-to-offset lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_cfg_pkg;

  // DMA core register offsets
  localparam logic [9:0] c_mm2s_dmacr  = 10'h000;
  localparam logic [9:0] c_mm2s_sa     = 10'h018;
  localparam logic [9:0] c_mm2s_length = 10'h028;
  localparam logic [9:0] c_s2mm_dmacr  = 10'h030;
  localparam logic [9:0] c_s2mm_da     = 10'h048;
  localparam logic [9:0] c_s2mm_length = 10'h058;

  // Control-register bits
  localparam logic [31:0] c_ctrl_rs         = 32'h0000_0001;
  localparam logic [31:0] c_ctrl_ioc_irq_en = 32'h0000_1000;

  // One-hot sequencer states
  typedef enum logic [3:0] {
    S_IDLE     = 4'b0001,
    S_ISSUE    = 4'b0010,
    S_WAIT_END = 4'b0100,
    S_DONE     = 4'b1000
  } state_t;

  // Register offset for a given channel direction and step (control, address, length)
  function automatic logic [9:0] step_offset(input logic dir, input logic [1:0] step);
    logic [9:0] off;
    case (step)
      2'd0:    off = dir ? c_s2mm_dmacr  : c_mm2s_dmacr;
      2'd1:    off = dir ? c_s2mm_da     : c_mm2s_sa;
      2'd2:    off = dir ? c_s2mm_length : c_mm2s_length;
      default: off = 10'h000;
    endcase
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module      : cfg_seq_wdog
// Description : Per-write watchdog for dma_cfg_seq. Counts cycles while run
//               is high, restarts on clear, and flags expiry once
//               TIMEOUT_CYCLES running cycles have elapsed.
//               Used only when CFG_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_seq_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned c_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT_CYCLES - 1);

  logic [c_w-1:0] r_cnt;

  // The final running cycle is the one in which the counter sits at TIMEOUT_CYCLES-1
  assign expired = run && (r_cnt == c_last);

  // Cycle counter: restarts on clear, advances while running, parks at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run && !expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : dma_cfg_seq
// Description : Expands one DMA transfer command into the control / address /
//               length register writes of the DMA core and drives them through
//               the AXI-Lite write controller's valid/end handshake.
//               Optional per-write watchdog: define CFG_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dma_cfg_seq
  import dma_cfg_pkg::*;
#(
  parameter bit          IRQ_EN         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [31:0] cmd_addr,
  input  logic [25:0] cmd_len,
  output logic [9:0]  lite_awaddr,
  output logic [31:0] lite_wdata,
  output logic        lite_valid,
  input  logic        lite_end,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] c_ctrl_word = IRQ_EN ? (c_ctrl_rs | c_ctrl_ioc_irq_en) : c_ctrl_rs;

  state_t      r_state;
  state_t      w_next;
  logic        r_dir;
  logic [31:0] r_addr;
  logic [25:0] r_len;
  logic [1:0]  r_step;
  logic        r_err;
  logic        w_accept;
  logic        w_in_write;
  logic        w_timeout;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_in_write = (r_state == S_ISSUE) || (r_state == S_WAIT_END);

`ifdef CFG_SEQ_TIMEOUT_EN
  logic w_wd_expired;

  cfg_seq_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state == S_ISSUE),
    .run     (r_state == S_WAIT_END),
    .expired (w_wd_expired)
  );

  // A completion arriving in the expiry cycle still wins over the abort
  assign w_timeout = w_wd_expired && !lite_end;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = (cmd_len == 26'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (lite_end) begin
          w_next = (r_step == 2'd2) ? S_DONE : S_ISSUE;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command capture, step counter and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir  <= 1'b0;
      r_addr <= '0;
      r_len  <= '0;
      r_step <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_dir  <= cmd_dir;
      r_addr <= cmd_addr;
      r_len  <= cmd_len;
      r_step <= '0;
      r_err  <= (cmd_len == 26'd0);
    end else if (r_state == S_WAIT_END) begin
      if (lite_end && (r_step != 2'd2)) begin
        r_step <= r_step + 2'd1;
      end else if (!lite_end && w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Write address/data: driven from the step table while a write is in flight
  always_comb begin
    lite_awaddr = '0;
    lite_wdata  = '0;
    if (w_in_write) begin
      lite_awaddr = step_offset(r_dir, r_step);
      case (r_step)
        2'd0:    lite_wdata = c_ctrl_word;
        2'd1:    lite_wdata = r_addr;
        default: lite_wdata = {6'b0, r_len};
      endcase
    end
  end

  assign lite_valid = (r_state == S_ISSUE);
  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_DONE) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_cfg_seq
// Description : Self-checking bench for dma_cfg_seq: directed scenarios plus
//               randomized commands against a register-sequence model.
//               Timeout scenario built when CFG_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_cfg_seq;

  localparam bit c_irq_en = 1'b1;
`ifdef CFG_SEQ_TIMEOUT_EN
  localparam int unsigned c_tmo = 16;
`else
  localparam int unsigned c_tmo = 1023;
`endif

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [31:0] cmd_addr;
  logic [25:0] cmd_len;
  logic [9:0]  lite_awaddr;
  logic [31:0] lite_wdata;
  logic        lite_valid;
  logic        lite_end;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  dma_cfg_seq #(
    .IRQ_EN         (c_irq_en),
    .TIMEOUT_CYCLES (c_tmo)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_dir     (cmd_dir),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .lite_awaddr (lite_awaddr),
    .lite_wdata  (lite_wdata),
    .lite_valid  (lite_valid),
    .lite_end    (lite_end),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_valid"}, 32'(lite_valid), 32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
    chk({tag, "_awaddr"}, 32'(lite_awaddr), 32'd0);
    chk({tag, "_wdata"}, lite_wdata,      32'd0);
  endtask

  // One full command: model derives the expected write list, bench plays the controller
  task automatic run_cmd(input logic dir, input logic [31:0] addr, input logic [25:0] len,
                         input int lat, input bit hold, input bit spur);
    logic [9:0]  ea [3];
    logic [31:0] ed [3];
    logic [9:0]  base;
    base  = dir ? 10'h030 : 10'h000;
    ea[0] = base;
    ea[1] = base + 10'h018;
    ea[2] = base + 10'h028;
    ed[0] = c_irq_en ? 32'h0000_1001 : 32'h0000_0001;
    ed[1] = addr;
    ed[2] = {6'b0, len};

    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_addr  = addr;
    cmd_len   = len;
    chk("ready_before_accept", 32'(cmd_ready), 32'd1);
    tick();
    if (hold) begin
      cmd_dir  = ~dir;
      cmd_addr = $urandom;
      cmd_len  = 26'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end

    if (len == 26'd0) begin
      chk("zero_done",  32'(done),       32'd1);
      chk("zero_err",   32'(err),        32'd1);
      chk("zero_valid", 32'(lite_valid), 32'd0);
      cmd_valid = 1'b0;
      tick();
      chk("zero_done_clear", 32'(done), 32'd0);
      chk("zero_valid_after", 32'(lite_valid), 32'd0);
      return;
    end

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("issue%0d_valid", i), 32'(lite_valid), 32'd1);
      chk($sformatf("issue%0d_awaddr", i), 32'(lite_awaddr), 32'(ea[i]));
      chk($sformatf("issue%0d_wdata", i), lite_wdata, ed[i]);
      chk($sformatf("issue%0d_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("issue%0d_busy", i), 32'(busy), 32'd1);
      lite_end = spur && (i == 0);
      for (int j = 0; j < lat; j++) begin
        tick();
        lite_end = (j == lat - 1);
        chk($sformatf("wait%0d_valid", i), 32'(lite_valid), 32'd0);
        chk($sformatf("wait%0d_awaddr", i), 32'(lite_awaddr), 32'(ea[i]));
        chk($sformatf("wait%0d_wdata", i), lite_wdata, ed[i]);
        chk($sformatf("wait%0d_done", i), 32'(done), 32'd0);
      end
      tick();
      lite_end = 1'b0;
    end

    chk("seq_done",  32'(done),       32'd1);
    chk("seq_err",   32'(err),        32'd0);
    chk("seq_valid", 32'(lite_valid), 32'd0);
    chk("seq_ready_in_done", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    tick();
    chk("post_done_clear", 32'(done),      32'd0);
    chk("post_ready",      32'(cmd_ready), 32'd1);
    chk("post_busy",       32'(busy),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    lite_end  = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("idle");

    // Directed: MM2S and S2MM from the plan
    run_cmd(1'b0, 32'h1000_0000, 26'h000_0400, 6, 1'b0, 1'b0);
    run_cmd(1'b1, 32'h2000_0040, 26'h3FF_FFFF, 3, 1'b0, 1'b0);
    // Zero length
    run_cmd(1'b1, 32'hDEAD_BEE0, 26'h0, 1, 1'b0, 1'b0);
    // cmd_valid held through the sequence plus spurious lite_end in ISSUE, twice back to back
    run_cmd(1'b0, 32'h0000_1234, 26'h000_0010, 2, 1'b1, 1'b1);
    run_cmd(1'b1, 32'h0ABC_0000, 26'h000_0020, 1, 1'b1, 1'b1);

    // Reset during WAIT_END of step 1
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_addr  = 32'h5555_0000;
    cmd_len   = 26'h100;
    tick();
    cmd_valid = 1'b0;
    tick();
    lite_end = 1'b1;
    tick();
    lite_end = 1'b0;
    chk("rst_step1_awaddr", 32'(lite_awaddr), 32'h048);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    chk("midrst_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_reset_vals("after_rst");
    run_cmd(1'b0, 32'h7777_0000, 26'h004, 2, 1'b0, 1'b0);

`ifdef CFG_SEQ_TIMEOUT_EN
    // Watchdog: lite_end withheld on step 0
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_addr  = 32'h1111_0000;
    cmd_len   = 26'h40;
    tick();
    cmd_valid = 1'b0;
    chk("tmo_issue_valid", 32'(lite_valid), 32'd1);
    for (int k = 0; k < int'(c_tmo); k++) begin
      tick();
      chk("tmo_wait_valid", 32'(lite_valid), 32'd0);
      chk("tmo_wait_done",  32'(done),       32'd0);
    end
    tick();
    chk("tmo_done",  32'(done),       32'd1);
    chk("tmo_err",   32'(err),        32'd1);
    chk("tmo_valid", 32'(lite_valid), 32'd0);
    tick();
    chk("tmo_idle_ready", 32'(cmd_ready),  32'd1);
    chk("tmo_idle_valid", 32'(lite_valid), 32'd0);
`endif

    // Randomized commands
    for (int n = 0; n < 10; n++) begin
      logic        rdir;
      logic [31:0] raddr;
      logic [25:0] rlen;
      rdir  = 1'($urandom_range(0, 1));
      raddr = $urandom;
      rlen  = ($urandom_range(0, 4) == 0) ? 26'd0 : 26'($urandom);
      run_cmd(rdir, raddr, rlen, int'($urandom_range(1, 8)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
